// File: rtl/sudoku_cmd_encoder.sv
// Turns raw buttons and keypad strobes into single-cycle, one-hot engine commands with debounce and spacing.
// Build option: define SUDOKU_CMD_AUTOREPEAT_EN to auto-repeat held direction buttons.
module sudoku_cmd_encoder #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int GAP_CYCLES      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_enter,
   input  logic       key_press,
   input  logic [3:0] key_code,
   input  logic       engine_ready,
   output logic       cmd_up,
   output logic       cmd_down,
   output logic       cmd_left,
   output logic       cmd_right,
   output logic       cmd_enter,
   output logic [3:0] cmd_number,
   output logic       cmd_valid
);

   // Source index order doubles as issue priority: up, down, left, right, number, enter.
   localparam int NSRC  = 6;
   localparam int SRC_NUM = 4;
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

   logic [NSRC-1:0] raw;
   logic [NSRC-1:0] sync1_q, sync2_q;
   logic [3:0]      code1_q, code2_q;
   logic [NSRC-1:0] rise, rep_fire, src_set;
   logic [NSRC-1:0] pend_q, pend_d, sel;
   logic [3:0]      digit_q, digit_d;
   logic            num_ok;

   state_t          state_q, state_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic            issue_go;
   logic            valid_q, valid_d;
   logic [4:0]      type_q, type_d;
   logic [3:0]      num_q, num_d;

   assign raw = {btn_enter, key_press, btn_right, btn_left, btn_down, btn_up};

   // key_code rides the same two-stage pipeline so it lines up with key_press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         code1_q <= '0;
         code2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         code1_q <= key_code;
         code2_q <= code1_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         logic [CNT_W-1:0] cnt_q;
         logic             deb_q;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt_q <= '0;
               deb_q <= 1'b0;
            end else if (sync2_q[gi] != deb_q) begin
               if (cnt_q == DB_LAST) begin
                  deb_q <= sync2_q[gi];
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end else begin
               cnt_q <= '0;
            end
         end

         // Rising edge of the debounced level, visible on the edge that commits it.
         assign rise[gi] = sync2_q[gi] & ~deb_q & (cnt_q == DB_LAST);

`ifdef SUDOKU_CMD_AUTOREPEAT_EN
         if (gi < 4) begin : g_rep
            localparam int REP_W = $clog2(8 * DEBOUNCE_CYCLES);
            localparam logic [REP_W-1:0] FIRST_LAST = REP_W'(8 * DEBOUNCE_CYCLES - 1);
            localparam logic [REP_W-1:0] NEXT_LAST  = REP_W'(4 * DEBOUNCE_CYCLES - 1);
            logic [REP_W-1:0] rep_cnt_q;
            logic             rep_first_q;
            logic             rep_hit;

            assign rep_hit = deb_q & (rep_cnt_q == (rep_first_q ? FIRST_LAST : NEXT_LAST));

            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  rep_cnt_q   <= '0;
                  rep_first_q <= 1'b1;
               end else if (!deb_q) begin
                  rep_cnt_q   <= '0;
                  rep_first_q <= 1'b1;
               end else if (rep_hit) begin
                  rep_cnt_q   <= '0;
                  rep_first_q <= 1'b0;
               end else begin
                  rep_cnt_q   <= rep_cnt_q + 1'b1;
               end
            end

            assign rep_fire[gi] = rep_hit;
         end else begin : g_norep
            assign rep_fire[gi] = 1'b0;
         end
`else
         assign rep_fire[gi] = 1'b0;
`endif
      end
   endgenerate

   // Digits 10..15 are not legal cell values and never become pending.
   assign num_ok = (code2_q <= 4'd9);

   always_comb begin
      src_set          = rise | rep_fire;
      src_set[SRC_NUM] = rise[SRC_NUM] & num_ok;
   end

   assign sel = pend_q & (~pend_q + NSRC'(1));

   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      issue_go  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pend_q && engine_ready) begin
               issue_go = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (GAP_CYCLES == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_GAP;
               gap_cnt_d = '0;
            end
         end
         ST_GAP: begin
            // The last gap cycle arbitrates like IDLE so pulses can be GAP_CYCLES+1 apart.
            if (gap_cnt_q == GAP_LAST) begin
               if (|pend_q && engine_ready) begin
                  issue_go = 1'b1;
                  state_d  = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pend_d  = pend_q;
      digit_d = digit_q;
      valid_d = 1'b0;
      type_d  = '0;
      num_d   = '0;
      if (issue_go) begin
         pend_d  = pend_q & ~sel;
         valid_d = 1'b1;
         type_d  = {sel[5], sel[3:0]};
         num_d   = sel[SRC_NUM] ? digit_q : 4'd0;
      end
      // A fresh press wins over a same-edge clear so it is never lost.
      pend_d = pend_d | src_set;
      if (src_set[SRC_NUM]) begin
         digit_d = code2_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         gap_cnt_q <= '0;
         pend_q    <= '0;
         digit_q   <= '0;
         valid_q   <= 1'b0;
         type_q    <= '0;
         num_q     <= '0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         pend_q    <= pend_d;
         digit_q   <= digit_d;
         valid_q   <= valid_d;
         type_q    <= type_d;
         num_q     <= num_d;
      end
   end

   assign cmd_valid  = valid_q;
   assign cmd_up     = type_q[0];
   assign cmd_down   = type_q[1];
   assign cmd_left   = type_q[2];
   assign cmd_right  = type_q[3];
   assign cmd_enter  = type_q[4];
   assign cmd_number = num_q;

endmodule

// File: tb/tb_sudoku_cmd_encoder.sv
// Directed bench for sudoku_cmd_encoder with DEBOUNCE_CYCLES=4, GAP_CYCLES=2.
module tb_sudoku_cmd_encoder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_enter = 0;
   logic       key_press = 0;
   logic [3:0] key_code = '0;
   logic       engine_ready = 1'b1;
   logic       cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, cmd_valid;
   logic [3:0] cmd_number;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int leak = 0;
   int p_cyc[$];
   logic [4:0] p_type[$];
   logic [3:0] p_num[$];

   sudoku_cmd_encoder #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_enter(btn_enter),
      .key_press(key_press), .key_code(key_code), .engine_ready(engine_ready),
      .cmd_up(cmd_up), .cmd_down(cmd_down), .cmd_left(cmd_left),
      .cmd_right(cmd_right), .cmd_enter(cmd_enter),
      .cmd_number(cmd_number), .cmd_valid(cmd_valid)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and log any command pulse; type is {up,down,left,right,enter}.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (cmd_valid === 1'b1) begin
         p_cyc.push_back(cyc);
         p_type.push_back({cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter});
         p_num.push_back(cmd_number);
         $display("cycle %0d: cmd type=%b number=%0d", cyc,
                  {cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter}, cmd_number);
      end else if ({cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, cmd_number} !== 9'd0) begin
         leak++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_log();
      p_cyc.delete();
      p_type.delete();
      p_num.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      run(3);
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", cmd_valid);
      end
      checks++;
      if ({cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter} !== 5'b0) begin
         errors++; $display("FAIL reset_type: got %b want 00000",
                            {cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter});
      end
      checks++;
      if (cmd_number !== 4'd0) begin
         errors++; $display("FAIL reset_number: got %0d want 0", cmd_number);
      end
      reset = 1'b1;
      clear_log();
      run(10);
      checks++;
      if (p_cyc.size() != 0) begin
         errors++; $display("FAIL reset_idle_pulses: got %0d want 0", p_cyc.size());
      end
   endtask

   task automatic test_single_press();
      int t0;
      clear_log();
      btn_right = 1'b1;
      t0 = cyc;
      run(20);
      btn_right = 1'b0;
      run(15);
      checks++;
      if (p_cyc.size() != 1) begin
         errors++; $display("FAIL right_count: got %0d want 1", p_cyc.size());
      end else begin
         checks++;
         if (p_cyc[0] != t0 + 7) begin
            errors++; $display("FAIL right_latency: got %0d want %0d", p_cyc[0] - t0, 7);
         end
         checks++;
         if (p_type[0] !== 5'b00010 || p_num[0] !== 4'd0) begin
            errors++; $display("FAIL right_type: got %b/%0d want 00010/0", p_type[0], p_num[0]);
         end
      end
   endtask

   task automatic test_bounce();
      int t0;
      clear_log();
      t0 = cyc;
      for (int i = 0; i < 10; i++) begin
         btn_up = ((i / 2) % 2 == 0);
         step();
      end
      btn_up = 1'b1;
      run(15);
      btn_up = 1'b0;
      run(15);
      checks++;
      if (p_cyc.size() != 1) begin
         errors++; $display("FAIL bounce_count: got %0d want 1", p_cyc.size());
      end else begin
         checks++;
         if (p_cyc[0] != t0 + 15 || p_type[0] !== 5'b10000) begin
            errors++; $display("FAIL bounce_pulse: got cyc %0d type %b want cyc 15 type 10000",
                               p_cyc[0] - t0, p_type[0]);
         end
      end
   endtask

   task automatic test_priority();
      int t0;
      int exp_off[3] = '{7, 10, 13};
      logic [4:0] exp_type[3] = '{5'b10000, 5'b00100, 5'b00000};
      logic [3:0] exp_num[3] = '{4'd0, 4'd0, 4'd7};
      clear_log();
      leak = 0;
      btn_up = 1'b1;
      btn_left = 1'b1;
      key_code = 4'd7;
      key_press = 1'b1;
      t0 = cyc;
      run(20);
      btn_up = 1'b0;
      btn_left = 1'b0;
      key_press = 1'b0;
      run(15);
      key_code = 4'd0;
      checks++;
      if (p_cyc.size() != 3) begin
         errors++; $display("FAIL prio_count: got %0d want 3", p_cyc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (p_cyc[i] != t0 + exp_off[i] || p_type[i] !== exp_type[i] || p_num[i] !== exp_num[i]) begin
               errors++;
               $display("FAIL prio_pulse%0d: got cyc %0d type %b num %0d want cyc %0d type %b num %0d",
                        i, p_cyc[i] - t0, p_type[i], p_num[i], exp_off[i], exp_type[i], exp_num[i]);
            end
         end
      end
      checks++;
      if (leak != 0) begin
         errors++; $display("FAIL prio_outputs_idle: got %0d nonzero idle cycles want 0", leak);
      end
   endtask

   task automatic test_number_range();
      logic [3:0] codes[4] = '{4'd12, 4'd0, 4'd9, 4'd10};
      int         want[4] = '{0, 1, 1, 0};
      int t0;
      for (int k = 0; k < 4; k++) begin
         clear_log();
         key_code = codes[k];
         key_press = 1'b1;
         t0 = cyc;
         run(12);
         key_press = 1'b0;
         run(12);
         checks++;
         if (p_cyc.size() != want[k]) begin
            errors++; $display("FAIL number_code%0d_count: got %0d want %0d", codes[k], p_cyc.size(), want[k]);
         end else if (want[k] == 1) begin
            checks++;
            if (p_cyc[0] != t0 + 7 || p_type[0] !== 5'b0 || p_num[0] !== codes[k]) begin
               errors++;
               $display("FAIL number_code%0d_pulse: got cyc %0d type %b num %0d want cyc 7 type 00000 num %0d",
                        codes[k], p_cyc[0] - t0, p_type[0], p_num[0], codes[k]);
            end
         end
      end
      key_code = 4'd0;
   endtask

   task automatic test_ready_gate();
      clear_log();
      engine_ready = 1'b0;
      btn_enter = 1'b1;
      run(50);
      checks++;
      if (p_cyc.size() != 0) begin
         errors++; $display("FAIL ready_blocked: got %0d pulses want 0", p_cyc.size());
      end
      engine_ready = 1'b1;
      step();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_enter !== 1'b1) begin
         errors++; $display("FAIL ready_enter: got valid %b enter %b want 1 1", cmd_valid, cmd_enter);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (cmd_valid !== 1'b0 || cmd_enter !== 1'b0) begin
         errors++; $display("FAIL reset_async_drop: got valid %b enter %b want 0 0", cmd_valid, cmd_enter);
      end
      btn_enter = 1'b0;
      run(3);
      reset = 1'b1;
      clear_log();
      run(20);
      checks++;
      if (p_cyc.size() != 0) begin
         errors++; $display("FAIL reset_no_replay: got %0d pulses want 0", p_cyc.size());
      end
   endtask

   task automatic test_held_through_reset();
      int t0;
      btn_left = 1'b1;
      reset = 1'b0;
      run(5);
      reset = 1'b1;
      clear_log();
      t0 = cyc;
      run(15);
      btn_left = 1'b0;
      run(15);
      checks++;
      if (p_cyc.size() != 1) begin
         errors++; $display("FAIL held_reset_count: got %0d want 1", p_cyc.size());
      end else begin
         checks++;
         if (p_cyc[0] != t0 + 7 || p_type[0] !== 5'b00100) begin
            errors++; $display("FAIL held_reset_pulse: got cyc %0d type %b want cyc 7 type 00100",
                               p_cyc[0] - t0, p_type[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      int exp_off[$];
`ifdef SUDOKU_CMD_AUTOREPEAT_EN
      exp_off = '{7, 39, 55, 71, 87, 103};
`else
      exp_off = '{7};
`endif
      clear_log();
      btn_down = 1'b1;
      t0 = cyc;
      run(100);
      btn_down = 1'b0;
      run(20);
      checks++;
      if (p_cyc.size() != exp_off.size()) begin
         errors++; $display("FAIL hold_down_count: got %0d want %0d", p_cyc.size(), exp_off.size());
      end else begin
         for (int i = 0; i < exp_off.size(); i++) begin
            checks++;
            if (p_cyc[i] != t0 + exp_off[i] || p_type[i] !== 5'b01000) begin
               errors++; $display("FAIL hold_down_pulse%0d: got cyc %0d type %b want cyc %0d type 01000",
                                  i, p_cyc[i] - t0, p_type[i], exp_off[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_priority();
      test_number_range();
      test_ready_gate();
      test_held_through_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sudoku_cmd_encoder.md
SUDOKU_CMD_ENCODER -- requirements
Module: sudoku_cmd_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles an input SHALL hold a new level before it is accepted.
REQ-002 Parameter GAP_CYCLES, default 4: minimum idle cycles SHALL separate two cmd_valid pulses.
REQ-003 Port clk, input, 1: single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Ports btn_up, btn_down, btn_left, btn_right, btn_enter, input, 1 each: raw, asynchronous, bouncing buttons, active-high.
REQ-006 Port key_press, input, 1: raw keypad strobe, active-high; key_code, input, 4: keypad digit, sampled with key_press.
REQ-007 Port engine_ready, input, 1: high when the engine accepts commands.
REQ-008 Ports cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, output, 1 each: command type, one-hot, qualified by cmd_valid.
REQ-009 Port cmd_number, output, 4: digit for a number command, qualified by cmd_valid.
REQ-010 Port cmd_valid, output, 1: single-cycle command strobe.

Function
REQ-011 Each of the 6 raw inputs SHALL pass a 2-flop synchronizer; key_code SHALL be captured from the synchronizer stage aligned with key_press.
REQ-012 Per input, a debounce counter SHALL count while the synchronized level differs from the debounced level, clear on agreement, and update the debounced level when it reaches DEBOUNCE_CYCLES.
REQ-013 A 0->1 debounced transition SHALL set that source's pending bit on the same edge; 1->0 transitions SHALL generate nothing.
REQ-014 A new press while the source is already pending SHALL merge (one command only); a new key press while number is pending SHALL overwrite the captured digit.
REQ-015 key_code values 10-15 SHALL be dropped (no pending bit set); 0 (clear cell) and 1-9 SHALL be accepted.
REQ-016 Issue FSM states: IDLE, ISSUE, GAP.
REQ-017 IDLE->ISSUE when any pending bit is set and engine_ready=1; otherwise stay IDLE and retain all pending bits.
REQ-018 ISSUE SHALL last exactly one cycle: cmd_valid=1, exactly one cmd_* type high (number type shown only by cmd_number with all direction/enter bits low), selected pending bit cleared.
REQ-019 Selection priority on simultaneous pending: up > down > left > right > number > enter; lower ones stay pending.
REQ-020 ISSUE->GAP; GAP SHALL last GAP_CYCLES cycles then return to IDLE; GAP_CYCLES=0 SHALL return to IDLE directly from ISSUE.
REQ-021 Outside ISSUE, cmd_valid, all cmd_* type bits and cmd_number SHALL be 0.
REQ-022 engine_ready falling during GAP SHALL not abort GAP; no command SHALL issue until it returns high.
REQ-023 Latency, idle engine: cmd_valid SHALL rise exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling a stable new raw level.

Reset
REQ-024 reset low SHALL immediately force all outputs to 0, FSM to IDLE, pending bits, synchronizers, debounced levels, counters and captured digit to 0.
REQ-025 Reset asserted during ISSUE SHALL drop cmd_valid asynchronously; the lost command SHALL not be replayed.
REQ-026 A button held through reset release SHALL produce one command after debounce (debounced level restarts at 0).

Configuration
REQ-027 Macro SUDOKU_CMD_AUTOREPEAT_EN: when defined, a direction button held debounced-high SHALL re-set its pending bit after 8*DEBOUNCE_CYCLES cycles, then every 4*DEBOUNCE_CYCLES cycles until release; enter and number never repeat.
REQ-028 Without SUDOKU_CMD_AUTOREPEAT_EN, exactly one command per debounced press; repeat counters SHALL not be synthesized.

Verification (bench: DEBOUNCE_CYCLES=4, GAP_CYCLES=2)
REQ-029 Clean btn_right press held 20 cycles, engine_ready=1 -> one cmd_valid with cmd_right=1, 7 edges after press; no second pulse.
REQ-030 btn_up bouncing 1/0 every 2 cycles for 10 cycles then stable high -> exactly one cmd_up pulse, none during bounce.
REQ-031 btn_up, btn_left and key_press with key_code=7 debounced same cycle -> pulses in order up, left, number 7, spaced by exactly 3 cycles (1 ISSUE + 2 GAP).
REQ-032 key_press with key_code=12 -> no cmd_valid; key_code=0 -> cmd_valid with cmd_number=0, all type bits 0.
REQ-033 btn_enter press while engine_ready=0 for 50 cycles -> no pulse; engine_ready rises -> cmd_enter pulse next cycle; reset low during ISSUE -> cmd_valid 0 immediately, nothing after release.
REQ-034 With SUDOKU_CMD_AUTOREPEAT_EN, btn_down held 100 cycles -> first pulse at 7, repeats at 7+32 then every 16 cycles until release; without the macro -> one pulse only.
